// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The master side is the controller: it takes the opcode, the ALU zero flag
// and the memory ready strobe, and drives every mux select and write enable.
interface mc_ctrl_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_write;
   logic       i_or_d;
   logic       ir_write;
   logic       pc_write;
   logic       pc_write_cond;
   logic       reg_write;
   logic [1:0] reg_dst_sel;
   logic [1:0] mem_to_reg_sel;
   logic       alu_src_a_sel;
   logic [1:0] alu_src_b_sel;
   logic [1:0] alu_op;
   logic [1:0] pc_src_sel;
   logic       illegal_op;
   logic       mem_err;
   logic [3:0] state_o;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
             reg_write, reg_dst_sel, mem_to_reg_sel, alu_src_a_sel,
             alu_src_b_sel, alu_op, pc_src_sel, illegal_op, mem_err, state_o
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
             reg_write, reg_dst_sel, mem_to_reg_sel, alu_src_a_sel,
             alu_src_b_sel, alu_op, pc_src_sel, illegal_op, mem_err, state_o
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit. Walks one instruction through a chain of
// states, stalling FETCH/MEMRD/MEMWR until mem_ready. Outputs are decoded
// combinationally from the current state (and mem_ready / opcode where the
// state needs them) and are forced low while rst is high.
// Optional: define MC_CTRL_JAL_EN to add the jal instruction (state JAL).
// MEM_TIMEOUT > 0 enables the sticky mem_err flag on long memory waits.
module mc_ctrl #(
   parameter int MEM_TIMEOUT = 0
) (
   input logic       clk,
   input logic       rst,
   mc_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JAL    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   state_t state;
   state_t state_nxt;
   logic   mem_wait;
   logic   mem_err_q;

   // Opcodes this build can dispatch from DECODE; anything else is illegal.
   function automatic logic op_supported(input logic [5:0] op);
      logic ok;
      ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MC_CTRL_JAL_EN
      ok = ok || (op == OP_JAL);
`endif
      return ok;
   endfunction

   // A memory state that did not complete this cycle.
   assign mem_wait = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                     && !bus.mem_ready;

   // State register; reset always restarts at FETCH, abandoning the instruction.
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

   // Next-state: memory states hold until mem_ready, DECODE dispatches on opcode.
   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:  state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:     state_nxt = S_EXEC;
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_J:         state_nxt = S_JUMP;
`ifdef MC_CTRL_JAL_EN
               OP_JAL:       state_nxt = S_JAL;
`endif
               default:      state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR: state_nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_nxt = S_FETCH;
         S_MEMWR:  state_nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_nxt = S_ALUWB;
         S_ALUWB:  state_nxt = S_FETCH;
         S_BRANCH: state_nxt = S_FETCH;
         S_JUMP:   state_nxt = S_FETCH;
         S_ADDIEX: state_nxt = S_ADDIWB;
         S_ADDIWB: state_nxt = S_FETCH;
         default:  state_nxt = S_FETCH;
      endcase
   end

   // Output decode: every select/enable defaults low, states raise only their own.
   always_comb begin
      bus.mem_req        = 1'b0;
      bus.mem_write      = 1'b0;
      bus.i_or_d         = 1'b0;
      bus.ir_write       = 1'b0;
      bus.pc_write       = 1'b0;
      bus.pc_write_cond  = 1'b0;
      bus.reg_write      = 1'b0;
      bus.reg_dst_sel    = 2'b00;
      bus.mem_to_reg_sel = 2'b00;
      bus.alu_src_a_sel  = 1'b0;
      bus.alu_src_b_sel  = 2'b00;
      bus.alu_op         = 2'b00;
      bus.pc_src_sel     = 2'b00;
      bus.illegal_op     = 1'b0;
      bus.state_o        = 4'd0;
      if (!rst) begin
         bus.state_o = state;
         case (state)
            S_FETCH: begin
               // PC+4 computed every cycle; IR and PC load only when the word arrives.
               bus.mem_req       = 1'b1;
               bus.alu_src_b_sel = 2'b01;
               bus.ir_write      = bus.mem_ready;
               bus.pc_write      = bus.mem_ready;
            end
            S_DECODE: begin
               bus.alu_src_b_sel = 2'b11;
               bus.illegal_op    = !op_supported(bus.opcode);
            end
            S_MEMADR, S_ADDIEX: begin
               bus.alu_src_a_sel = 1'b1;
               bus.alu_src_b_sel = 2'b10;
            end
            S_MEMRD: begin
               bus.mem_req = 1'b1;
               bus.i_or_d  = 1'b1;
            end
            S_MEMWB: begin
               bus.reg_write      = 1'b1;
               bus.mem_to_reg_sel = 2'b01;
            end
            S_MEMWR: begin
               bus.mem_req   = 1'b1;
               bus.mem_write = 1'b1;
               bus.i_or_d    = 1'b1;
            end
            S_EXEC: begin
               bus.alu_src_a_sel = 1'b1;
               bus.alu_op        = 2'b10;
            end
            S_ALUWB: begin
               bus.reg_write   = 1'b1;
               bus.reg_dst_sel = 2'b01;
            end
            S_BRANCH: begin
               bus.alu_src_a_sel = 1'b1;
               bus.alu_op        = 2'b01;
               bus.pc_write_cond = 1'b1;
               bus.pc_src_sel    = 2'b01;
            end
            S_JUMP: begin
               bus.pc_write   = 1'b1;
               bus.pc_src_sel = 2'b10;
            end
            S_ADDIWB: begin
               bus.reg_write = 1'b1;
            end
`ifdef MC_CTRL_JAL_EN
            S_JAL: begin
               // PC already holds PC+4 from FETCH, so $31 receives the return address.
               bus.reg_write      = 1'b1;
               bus.reg_dst_sel    = 2'b10;
               bus.mem_to_reg_sel = 2'b10;
               bus.pc_write       = 1'b1;
               bus.pc_src_sel     = 2'b10;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.mem_err = mem_err_q & ~rst;

   generate
      if (MEM_TIMEOUT > 0) begin : g_timeout
         localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
         logic [CNT_W-1:0] wait_cnt;

         // Count consecutive wait cycles; the MEM_TIMEOUT-th one without ready flags the error.
         always_ff @(posedge clk) begin
            if (rst) begin
               wait_cnt  <= '0;
               mem_err_q <= 1'b0;
            end else if (mem_wait) begin
               if (wait_cnt == CNT_LAST) mem_err_q <= 1'b1;
               else                      wait_cnt  <= wait_cnt + 1'b1;
            end else begin
               wait_cnt <= '0;
            end
         end
      end else begin : g_no_timeout
         assign mem_err_q = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl (MEM_TIMEOUT=4). The stimulus process drives one
// directed vector per cycle and queues the hand-derived expected outputs; a
// monitor pops one entry per cycle at the falling edge and compares.
// Honours MC_CTRL_JAL_EN to pick the jal or illegal-000011 expectation.
module tb_mc_ctrl;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req;
      logic       mem_write;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       reg_write;
      logic [1:0] reg_dst_sel;
      logic [1:0] mem_to_reg_sel;
      logic       alu_src_a_sel;
      logic [1:0] alu_src_b_sel;
      logic [1:0] alu_op;
      logic [1:0] pc_src_sel;
      logic       illegal_op;
      logic       mem_err;
   } outs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   mc_ctrl_if bus();

   outs_t expq[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   bit    stim_done = 1'b0;

   mc_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Expected outputs for one cycle, written out from the control table by state.
   function automatic outs_t exp_of(input bit r, input int st, input bit rdy,
                                    input bit ill, input bit err);
      outs_t e;
      e = '0;
      if (r) return e;
      e.st = 4'(st);
      e.illegal_op = ill;
      e.mem_err = err;
      case (st)
         0:  begin e.mem_req = 1; e.alu_src_b_sel = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
         1:  e.alu_src_b_sel = 2'b11;
         2:  begin e.alu_src_a_sel = 1; e.alu_src_b_sel = 2'b10; end
         3:  begin e.mem_req = 1; e.i_or_d = 1; end
         4:  begin e.reg_write = 1; e.mem_to_reg_sel = 2'b01; end
         5:  begin e.mem_req = 1; e.mem_write = 1; e.i_or_d = 1; end
         6:  begin e.alu_src_a_sel = 1; e.alu_op = 2'b10; end
         7:  begin e.reg_write = 1; e.reg_dst_sel = 2'b01; end
         8:  begin e.alu_src_a_sel = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_src_sel = 2'b01; end
         9:  begin e.pc_write = 1; e.pc_src_sel = 2'b10; end
         10: begin e.alu_src_a_sel = 1; e.alu_src_b_sel = 2'b10; end
         11: e.reg_write = 1;
         12: begin e.reg_write = 1; e.reg_dst_sel = 2'b10; e.mem_to_reg_sel = 2'b10;
                   e.pc_write = 1; e.pc_src_sel = 2'b10; end
         default: ;
      endcase
      return e;
   endfunction

   // One cycle: drive inputs just after the rising edge, queue what must appear.
   task automatic cyc(input bit r, input logic [5:0] op, input bit rdy,
                      input int st, input bit ill, input bit err);
      @(posedge clk);
      #1;
      rst = r;
      bus.opcode = op;
      bus.mem_ready = rdy;
      expq.push_back(exp_of(r, st, rdy, ill, err));
   endtask

   // Monitor: one comparison per queued cycle.
   initial begin : monitor
      outs_t act;
      outs_t exp_v;
      int idx;
      idx = 0;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            exp_v = expq.pop_front();
            act.st             = bus.state_o;
            act.mem_req        = bus.mem_req;
            act.mem_write      = bus.mem_write;
            act.i_or_d         = bus.i_or_d;
            act.ir_write       = bus.ir_write;
            act.pc_write       = bus.pc_write;
            act.pc_write_cond  = bus.pc_write_cond;
            act.reg_write      = bus.reg_write;
            act.reg_dst_sel    = bus.reg_dst_sel;
            act.mem_to_reg_sel = bus.mem_to_reg_sel;
            act.alu_src_a_sel  = bus.alu_src_a_sel;
            act.alu_src_b_sel  = bus.alu_src_b_sel;
            act.alu_op         = bus.alu_op;
            act.pc_src_sel     = bus.pc_src_sel;
            act.illegal_op     = bus.illegal_op;
            act.mem_err        = bus.mem_err;
            n_checks++;
            if (act !== exp_v) begin
               n_fail++;
               $display("FAIL cycle %0d (state %0d): actual %h required %h",
                        idx, exp_v.st, act, exp_v);
            end
            idx++;
         end
      end
   end

   // Directed stimulus.
   initial begin : stimulus
      bus.opcode = 6'd0;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b1;

      // reset held two cycles with mem_ready high
      cyc(1, 6'h00, 1, 0, 0, 0);
      cyc(1, 6'h00, 1, 0, 0, 0);
      // R-type: 0,1,6,7
      cyc(0, 6'h00, 1, 0, 0, 0);
      cyc(0, 6'h00, 1, 1, 0, 0);
      cyc(0, 6'h00, 1, 6, 0, 0);
      cyc(0, 6'h00, 1, 7, 0, 0);
      // lw with three wait cycles in MEMRD: 8 cycles
      cyc(0, 6'h23, 1, 0, 0, 0);
      cyc(0, 6'h23, 1, 1, 0, 0);
      cyc(0, 6'h23, 1, 2, 0, 0);
      cyc(0, 6'h23, 0, 3, 0, 0);
      cyc(0, 6'h23, 0, 3, 0, 0);
      cyc(0, 6'h23, 0, 3, 0, 0);
      cyc(0, 6'h23, 1, 3, 0, 0);
      cyc(0, 6'h23, 1, 4, 0, 0);
      // sw
      cyc(0, 6'h2B, 1, 0, 0, 0);
      cyc(0, 6'h2B, 1, 1, 0, 0);
      cyc(0, 6'h2B, 1, 2, 0, 0);
      cyc(0, 6'h2B, 1, 5, 0, 0);
      // beq
      cyc(0, 6'h04, 1, 0, 0, 0);
      cyc(0, 6'h04, 1, 1, 0, 0);
      cyc(0, 6'h04, 1, 8, 0, 0);
      // addi
      cyc(0, 6'h08, 1, 0, 0, 0);
      cyc(0, 6'h08, 1, 1, 0, 0);
      cyc(0, 6'h08, 1, 10, 0, 0);
      cyc(0, 6'h08, 1, 11, 0, 0);
      // j
      cyc(0, 6'h02, 1, 0, 0, 0);
      cyc(0, 6'h02, 1, 1, 0, 0);
      cyc(0, 6'h02, 1, 9, 0, 0);
      // illegal opcode 111111
      cyc(0, 6'h3F, 1, 0, 0, 0);
      cyc(0, 6'h3F, 1, 1, 1, 0);
      // opcode 000011: jal when enabled, illegal otherwise
      cyc(0, 6'h03, 1, 0, 0, 0);
`ifdef MC_CTRL_JAL_EN
      cyc(0, 6'h03, 1, 1, 0, 0);
      cyc(0, 6'h03, 1, 12, 0, 0);
`else
      cyc(0, 6'h03, 1, 1, 1, 0);
`endif
      // reset in the middle of an R-type aborts it: EXEC never reaches ALUWB
      cyc(0, 6'h00, 1, 0, 0, 0);
      cyc(0, 6'h00, 1, 1, 0, 0);
      cyc(1, 6'h00, 1, 0, 0, 0);
      // timeout: four waits in FETCH, flag then visible and sticky
      cyc(0, 6'h00, 0, 0, 0, 0);
      cyc(0, 6'h00, 0, 0, 0, 0);
      cyc(0, 6'h00, 0, 0, 0, 0);
      cyc(0, 6'h00, 0, 0, 0, 0);
      cyc(0, 6'h00, 0, 0, 0, 1);
      cyc(0, 6'h00, 1, 0, 0, 1);
      cyc(0, 6'h00, 1, 1, 0, 1);
      cyc(0, 6'h00, 1, 6, 0, 1);
      cyc(0, 6'h00, 1, 7, 0, 1);
      // reset clears the sticky flag
      cyc(1, 6'h00, 1, 0, 0, 0);
      // ready on the fourth wait cycle wins over the timeout
      cyc(0, 6'h00, 0, 0, 0, 0);
      cyc(0, 6'h00, 0, 0, 0, 0);
      cyc(0, 6'h00, 0, 0, 0, 0);
      cyc(0, 6'h00, 1, 0, 0, 0);
      cyc(0, 6'h3F, 1, 1, 1, 0);
      cyc(0, 6'h00, 1, 0, 0, 0);

      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (expq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: actual %0d entries left, required 0", expq.size());
      end
      stim_done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin : watchdog
      #20000;
      if (!stim_done) begin
         $display("FAIL watchdog: actual timeout, required stimulus completion");
         $fatal(1, "watchdog expired");
      end
   end

endmodule
